load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the execute ALU: takes the ALU result as effective address, performs
//  one load or store on a simple valid/ready data bus, aligns/extends load data and hands a result to writeback.
//  Non-memory ops pass the ALU result through. One access in flight; ready_out throttles execute.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ without bus_ready_in before access fault (1..65535)
// PORTS
//  clk_in          in   1   single clock, rising edge
//  rst_n_in        in   1   reset, asynchronous, active-low
//  valid_in        in   1   execute presents an op
//  ready_out       out  1   unit can accept (high only in IDLE)
//  load_in         in   1   op is a load
//  store_in        in   1   op is a store (load_in&store_in never both set)
//  width_in        in   2   00 byte, 01 half, 10 word, 11 dword
//  unsigned_in     in   1   zero-extend load (LBU/LHU/LWU)
//  addr_in         in   64  ALU result: address, or pass-through value
//  store_data_in   in   64  rs2 value
//  rd_in           in   5   destination register
//  flush_in        in   1   kill current/arriving op
//  valid_out       out  1   one-cycle result pulse to writeback
//  rd_out          out  5   destination register of result
//  result_out      out  64  load data / pass-through value / 0 on fault
//  fault_out       out  1   qualifies valid_out: bus timeout or misaligned
//  bus_valid_out   out  1   bus request
//  bus_ready_in    in   1   bus completes request this cycle
//  bus_we_out      out  1   1 = write
//  bus_addr_out    out  64  {addr[63:3],3'b000}
//  bus_wstrb_out   out  8   byte enables
//  bus_wdata_out   out  64  store data shifted to byte lane
//  bus_rdata_in    in   64  read data, valid when bus_valid_out&bus_ready_in&!bus_we_out
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except ready_out=1; timeout counter 0; takes effect immediately (bus_valid_out drops).
//  FSM IDLE->REQ (accept valid_in&ready_out with load/store), IDLE->DONE (accept non-memory op),
//   REQ->DONE (bus_ready_in, or counter==TIMEOUT_CYCLES-1), DONE->IDLE (always).
//  Latency: non-memory op 1 cycle accept->valid_out; memory op = bus wait cycles + 2.
//  REQ: bus outputs registered at accept, held stable until bus_ready_in; read data captured on handshake.
//  Store align: wstrb = {1,3,F,FF}[width] << addr[2:0]; wdata = store_data << 8*addr[2:0].
//  Load extract: data = rdata >> 8*addr[2:0], truncate to width, sign-extend unless unsigned_in (dword ignores it).
//  Stores: valid_out pulses with rd_out=0, result_out=0.
//  Timeout: counter increments each REQ cycle w/o ready; on expiry bus_valid_out drops, DONE with fault_out=1, result 0.
//  Flush: IDLE with flush_in&valid_in -> op discarded. Flush in REQ -> bus request still completes (no abandon),
//   valid_out suppressed in DONE. Flush in DONE -> valid_out suppressed. Counter cleared on every accept.
//  valid_out/fault_out/rd_out/result_out registered, high for exactly the DONE cycle, else 0.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: access with addr[2:0] not multiple of size goes IDLE->DONE with no bus request,
//   fault_out=1, result 0. Undefined: low address bits forced to size alignment, access proceeds, no fault.
// STRUCTURE
//  lsu_pkg: width enum (LSU_W_B/H/W/D), state enum (LSU_IDLE/REQ/DONE), strobe-mask constant table.
//  Sub-module lsu_align: combinational store lane-shift/strobe and load extract/extend; FSM/counter in top.
// TESTING
//  LD addr=0x1000, rdata=0x1122334455667788, ready after 3 cycles -> valid_out 1 cycle, result=0x1122334455667788.
//  LB addr=0x1003 rdata byte3=0x80 -> result=0xFFFFFFFFFFFFFF80; LBU same -> 0x80; LWU addr=0x1004 -> upper word zero-ext.
//  SH addr=0x2006 data=0xBEEF -> wstrb=0xC0, wdata[63:48]=0xBEEF, addr_out=0x2000, valid_out with rd_out=0.
//  Bus never ready, TIMEOUT_CYCLES=4 -> bus_valid_out high 4 cycles, then valid_out&fault_out, result 0.
//  flush_in during REQ -> handshake completes, no valid_out; rst_n_in low mid-REQ -> bus_valid_out 0 same cycle, ready_out 1.
//  LW addr=0x1002: with LSU_MISALIGN_TRAP_EN -> fault_out, no bus_valid_out; without -> access at word 0x1000.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store unit: access
//                width encoding, FSM state encoding, byte-strobe mask table
//                and an access-size alignment mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_W_B = 2'b00,
    LSU_W_H = 2'b01,
    LSU_W_W = 2'b10,
    LSU_W_D = 2'b11
  } lsu_width_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_e;

  // Byte-enable pattern of an access at lane 0, indexed by width.
  localparam logic [7:0] C_STRB_MASK [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] lsu_lo_mask(input lsu_width_e width);
    case (width)
      LSU_W_B: lsu_lo_mask = 3'b000;
      LSU_W_H: lsu_lo_mask = 3'b001;
      LSU_W_W: lsu_lo_mask = 3'b011;
      default: lsu_lo_mask = 3'b111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational data-path helper. Store side shifts store data
//                and the strobe mask into the addressed byte lane. Load side
//                extracts the addressed bytes from a bus word and zero/sign
//                extends them to 64 bits.
//  Ports       : st_width/st_off/st_data -> st_wstrb/st_wdata
//                ld_width/ld_off/ld_unsigned/ld_rdata -> ld_data
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_width_e  st_width,
  input  logic [2:0]  st_off,
  input  logic [63:0] st_data,
  output logic [7:0]  st_wstrb,
  output logic [63:0] st_wdata,
  input  lsu_width_e  ld_width,
  input  logic [2:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [63:0] ld_rdata,
  output logic [63:0] ld_data
);

  logic [63:0] w_ld_shift;
  logic        w_sext;

  assign st_wstrb   = C_STRB_MASK[st_width] << st_off;
  assign st_wdata   = st_data << {st_off, 3'b000};

  assign w_ld_shift = ld_rdata >> {ld_off, 3'b000};
  assign w_sext     = ~ld_unsigned;

  always_comb begin
    ld_data = w_ld_shift;
    case (ld_width)
      LSU_W_B: ld_data = {{56{w_sext & w_ld_shift[7]}},  w_ld_shift[7:0]};
      LSU_W_H: ld_data = {{48{w_sext & w_ld_shift[15]}}, w_ld_shift[15:0]};
      LSU_W_W: ld_data = {{32{w_sext & w_ld_shift[31]}}, w_ld_shift[31:0]};
      default: ld_data = w_ld_shift;  // dword ignores the unsigned flag
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory stage behind the execute ALU. Uses the ALU result as
//                effective address for one load or store on a valid/ready
//                bus, aligns/extends load data and hands a one-cycle result
//                pulse to writeback. Non-memory ops pass the ALU result
//                through. One access in flight; ready_out throttles execute.
//  Config      : LSU_MISALIGN_TRAP_EN - when defined, misaligned accesses
//                fault without a bus request; otherwise the low address bits
//                are forced to size alignment and the access proceeds.
//  Ports       : execute side  valid_in/ready_out, op fields, flush_in
//                writeback     valid_out, rd_out, result_out, fault_out
//                data bus      bus_valid_out/bus_ready_in, we/addr/wstrb/
//                              wdata out, rdata in
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [1:0]  width_in,
  input  logic        unsigned_in,
  input  logic [63:0] addr_in,
  input  logic [63:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        flush_in,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic [63:0] result_out,
  output logic        fault_out,
  output logic        bus_valid_out,
  input  logic        bus_ready_in,
  output logic        bus_we_out,
  output logic [63:0] bus_addr_out,
  output logic [7:0]  bus_wstrb_out,
  output logic [63:0] bus_wdata_out,
  input  logic [63:0] bus_rdata_in
);

  localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e  r_state;
  logic [15:0] r_cnt;
  logic        r_bus_valid;
  logic        r_bus_we;
  logic [63:0] r_bus_addr;
  logic [7:0]  r_bus_wstrb;
  logic [63:0] r_bus_wdata;
  logic        r_is_store;
  logic [4:0]  r_rd;
  logic [2:0]  r_off;
  lsu_width_e  r_width;
  logic        r_unsigned;
  logic        r_flushed;
  logic        r_valid;
  logic        r_fault;
  logic [4:0]  r_rd_out;
  logic [63:0] r_result;

  lsu_width_e  w_width;
  logic        w_mem_op;
  logic [2:0]  w_off;
  logic        w_trap;
  logic        w_kill;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata;
  logic [63:0] w_load_data;

  assign w_width  = lsu_width_e'(width_in);
  assign w_mem_op = load_in | store_in;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_off  = addr_in[2:0];
  assign w_trap = w_mem_op && ((addr_in[2:0] & lsu_lo_mask(w_width)) != 3'b000);
`else
  assign w_off  = addr_in[2:0] & ~lsu_lo_mask(w_width);
  assign w_trap = 1'b0;
`endif

  // A flush seen at any point of the access (earlier or this cycle) kills the result.
  assign w_kill = r_flushed | flush_in;

  lsu_align u_align (
    .st_width    (w_width),
    .st_off      (w_off),
    .st_data     (store_data_in),
    .st_wstrb    (w_wstrb),
    .st_wdata    (w_wdata),
    .ld_width    (r_width),
    .ld_off      (r_off),
    .ld_unsigned (r_unsigned),
    .ld_rdata    (bus_rdata_in),
    .ld_data     (w_load_data)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= LSU_IDLE;
      r_cnt       <= '0;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wstrb <= '0;
      r_bus_wdata <= '0;
      r_is_store  <= 1'b0;
      r_rd        <= '0;
      r_off       <= '0;
      r_width     <= LSU_W_B;
      r_unsigned  <= 1'b0;
      r_flushed   <= 1'b0;
      r_valid     <= 1'b0;
      r_fault     <= 1'b0;
      r_rd_out    <= '0;
      r_result    <= '0;
    end else begin
      // Result registers are only non-zero for the single DONE cycle.
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
      r_rd_out <= '0;
      r_result <= '0;
      case (r_state)
        LSU_IDLE: begin
          if (valid_in && !flush_in) begin
            r_cnt      <= '0;
            r_flushed  <= 1'b0;
            r_rd       <= rd_in;
            r_off      <= w_off;
            r_width    <= w_width;
            r_unsigned <= unsigned_in;
            r_is_store <= store_in;
            if (!w_mem_op) begin
              r_state  <= LSU_DONE;
              r_valid  <= 1'b1;
              r_rd_out <= rd_in;
              r_result <= addr_in;
            end else if (w_trap) begin
              r_state  <= LSU_DONE;
              r_valid  <= 1'b1;
              r_fault  <= 1'b1;
              r_rd_out <= store_in ? 5'd0 : rd_in;
            end else begin
              r_state     <= LSU_REQ;
              r_bus_valid <= 1'b1;
              r_bus_we    <= store_in;
              r_bus_addr  <= {addr_in[63:3], 3'b000};
              r_bus_wstrb <= store_in ? w_wstrb : 8'h00;
              r_bus_wdata <= store_in ? w_wdata : 64'd0;
            end
          end
        end

        LSU_REQ: begin
          if (flush_in) r_flushed <= 1'b1;
          if (bus_ready_in || (r_cnt == C_TIMEOUT_LAST)) begin
            r_state     <= LSU_DONE;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_wstrb <= '0;
            r_bus_wdata <= '0;
            if (!w_kill) begin
              r_valid  <= 1'b1;
              r_rd_out <= r_is_store ? 5'd0 : r_rd;
              if (bus_ready_in) begin
                r_result <= r_is_store ? 64'd0 : w_load_data;
              end else begin
                r_fault  <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: r_state <= LSU_IDLE;  // DONE always returns to IDLE
      endcase
    end
  end

  assign ready_out     = (r_state == LSU_IDLE);
  // A flush arriving during DONE still suppresses the already-registered pulse.
  assign valid_out     = r_valid & ~flush_in;
  assign fault_out     = r_fault & ~flush_in;
  assign rd_out        = flush_in ? 5'd0  : r_rd_out;
  assign result_out    = flush_in ? 64'd0 : r_result;
  assign bus_valid_out = r_bus_valid;
  assign bus_we_out    = r_bus_we;
  assign bus_addr_out  = r_bus_addr;
  assign bus_wstrb_out = r_bus_wstrb;
  assign bus_wdata_out = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. A byte-addressed
//                memory model answers bus requests; expected load values,
//                strobes and lane data are rebuilt byte by byte from it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        load_in = 1'b0;
  logic        store_in = 1'b0;
  logic [1:0]  width_in = 2'd0;
  logic        unsigned_in = 1'b0;
  logic [63:0] addr_in = '0;
  logic [63:0] store_data_in = '0;
  logic [4:0]  rd_in = '0;
  logic        flush_in = 1'b0;
  logic        valid_out;
  logic [4:0]  rd_out;
  logic [63:0] result_out;
  logic        fault_out;
  logic        bus_valid_out;
  logic        bus_ready_in = 1'b0;
  logic        bus_we_out;
  logic [63:0] bus_addr_out;
  logic [7:0]  bus_wstrb_out;
  logic [63:0] bus_wdata_out;
  logic [63:0] bus_rdata_in = '0;

  int checks = 0;
  int failures = 0;

  logic [63:0] mem [longint];

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(ready_out),
    .load_in(load_in), .store_in(store_in), .width_in(width_in), .unsigned_in(unsigned_in),
    .addr_in(addr_in), .store_data_in(store_data_in), .rd_in(rd_in), .flush_in(flush_in),
    .valid_out(valid_out), .rd_out(rd_out), .result_out(result_out), .fault_out(fault_out),
    .bus_valid_out(bus_valid_out), .bus_ready_in(bus_ready_in), .bus_we_out(bus_we_out),
    .bus_addr_out(bus_addr_out), .bus_wstrb_out(bus_wstrb_out), .bus_wdata_out(bus_wdata_out),
    .bus_rdata_in(bus_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input longint key);
    if (!mem.exists(key)) mem[key] = {$urandom, $urandom};
    return mem[key];
  endfunction

  // Present one op on the execute interface for exactly one accepting edge.
  task automatic issue(input int kind, input logic [1:0] w, input logic uns,
                       input logic [63:0] a, input logic [63:0] d, input logic [4:0] rd);
    @(negedge clk_in);
    check("ready_before_issue", {63'd0, ready_out}, 64'd1);
    valid_in = 1'b1; load_in = (kind == 1); store_in = (kind == 2);
    width_in = w; unsigned_in = uns; addr_in = a; store_data_in = d; rd_in = rd;
    @(posedge clk_in); #1;
    valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0;
  endtask

  // kind: 0 = pass-through, 1 = load, 2 = store; dly = bus wait cycles.
  task automatic run_op(input int kind, input logic [1:0] w, input logic uns,
                        input logic [63:0] a, input logic [63:0] d, input logic [4:0] rd,
                        input int dly);
    int          n, off, lat, waited, exp_lat;
    bit          mis, trap, got, seen, mem_op;
    logic [63:0] word, exp_res, exp_wdata;
    logic [7:0]  exp_strb;
    longint      key;
    n = 1 << w;
    mem_op = (kind != 0);
    mis = (a[2:0] % n) != 0;
    trap = TRAP && mis && mem_op;
    off = int'(a[2:0]);
    if (!TRAP) off = off - (off % n);
    key = longint'(a >> 3);
    word = mem_rd(key);
    exp_res = 64'd0;
    for (int i = 0; i < n; i++) exp_res[8*i +: 8] = word[8*(off+i) +: 8];
    if (!uns && n < 8 && exp_res[8*n-1]) for (int b = 8*n; b < 64; b++) exp_res[b] = 1'b1;
    exp_strb = 8'd0;
    for (int i = 0; i < n; i++) exp_strb[off+i] = 1'b1;
    exp_wdata = d << (8*off);
    exp_lat = (!mem_op || trap) ? 1 : dly + 2;

    issue(kind, w, uns, a, d, rd);
    lat = 0; waited = 0; got = 0; seen = 0;
    for (int c = 0; c < dly + 20 && !got; c++) begin
      @(negedge clk_in);
      lat++;
      bus_ready_in = 1'b0;
      bus_rdata_in = {$urandom, $urandom};
      if (valid_out) begin
        got = 1;
      end else if (bus_valid_out) begin
        if (!seen) begin
          check("bus_addr", bus_addr_out, {a[63:3], 3'b000});
          check("bus_we", {63'd0, bus_we_out}, {63'd0, kind == 2});
          if (kind == 2) begin
            check("bus_wstrb", {56'd0, bus_wstrb_out}, {56'd0, exp_strb});
            check("bus_wdata", bus_wdata_out, exp_wdata);
          end
        end
        seen = 1;
        if (waited == dly) begin
          bus_ready_in = 1'b1;
          bus_rdata_in = word;
        end else waited++;
      end
    end
    bus_ready_in = 1'b0;
    check("valid_out_seen", {63'd0, got}, 64'd1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("bus_request_made", {63'd0, seen}, {63'd0, mem_op && !trap});
    check("fault", {63'd0, fault_out}, {63'd0, trap});
    if (trap) check("fault_result", result_out, 64'd0);
    else if (kind == 0) begin
      check("pass_rd", {59'd0, rd_out}, {59'd0, rd});
      check("pass_result", result_out, a);
    end else if (kind == 1) begin
      check("load_rd", {59'd0, rd_out}, {59'd0, rd});
      check("load_result", result_out, exp_res);
    end else begin
      check("store_rd", {59'd0, rd_out}, 64'd0);
      check("store_result", result_out, 64'd0);
    end
    @(negedge clk_in);
    check("valid_one_cycle", {63'd0, valid_out}, 64'd0);
    if (kind == 2 && !trap)
      for (int i = 0; i < 8; i++) if (exp_strb[i]) mem[key][8*i +: 8] = exp_wdata[8*i +: 8];
  endtask

  initial begin
    int cnt;
    bit seen_valid;
    // Reset state
    #12;
    check("rst_ready", {63'd0, ready_out}, 64'd1);
    check("rst_valid", {63'd0, valid_out}, 64'd0);
    check("rst_bus_valid", {63'd0, bus_valid_out}, 64'd0);
    check("rst_fault", {63'd0, fault_out}, 64'd0);
    check("rst_result", result_out, 64'd0);
    @(negedge clk_in); rst_n_in = 1'b1;

    // Directed cases
    mem[64'h1000 >> 3] = 64'h1122334455667788;
    run_op(1, 2'b11, 1'b0, 64'h1000, 64'd0, 5'd3, 3);
    mem[64'h1000 >> 3] = 64'h1122334480667788;
    run_op(1, 2'b00, 1'b0, 64'h1003, 64'd0, 5'd4, 1);
    run_op(1, 2'b00, 1'b1, 64'h1003, 64'd0, 5'd5, 0);
    run_op(1, 2'b10, 1'b1, 64'h1004, 64'd0, 5'd6, 2);
    run_op(2, 2'b01, 1'b0, 64'h2006, 64'hBEEF, 5'd7, 1);
    run_op(1, 2'b10, 1'b0, 64'h1002, 64'd0, 5'd8, 0);
    run_op(0, 2'b00, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'd0, 5'd9, 0);

    // Timeout: bus never ready
    issue(1, 2'b11, 1'b0, 64'h3000, 64'd0, 5'd10);
    cnt = 0; seen_valid = 0;
    for (int c = 0; c < 20 && !seen_valid; c++) begin
      @(negedge clk_in);
      if (bus_valid_out) cnt++;
      if (valid_out) begin
        seen_valid = 1;
        check("timeout_fault", {63'd0, fault_out}, 64'd1);
        check("timeout_result", result_out, 64'd0);
      end
    end
    check("timeout_valid_seen", {63'd0, seen_valid}, 64'd1);
    check("timeout_req_cycles", 64'(cnt), 64'd4);

    // Flush during REQ: handshake still happens, no result
    issue(1, 2'b11, 1'b0, 64'h3008, 64'd0, 5'd11);
    @(negedge clk_in); flush_in = 1'b1;
    @(negedge clk_in); flush_in = 1'b0;
    check("flush_req_bus_held", {63'd0, bus_valid_out}, 64'd1);
    bus_ready_in = 1'b1;
    @(negedge clk_in); bus_ready_in = 1'b0;
    check("flush_req_bus_done", {63'd0, bus_valid_out}, 64'd0);
    check("flush_req_no_valid", {63'd0, valid_out}, 64'd0);
    @(negedge clk_in);
    check("flush_req_idle", {63'd0, ready_out}, 64'd1);

    // Flush arriving with the op in IDLE discards it
    @(negedge clk_in);
    valid_in = 1'b1; flush_in = 1'b1; rd_in = 5'd12; addr_in = 64'h55;
    @(negedge clk_in);
    valid_in = 1'b0; flush_in = 1'b0;
    check("flush_idle_no_valid", {63'd0, valid_out}, 64'd0);
    check("flush_idle_ready", {63'd0, ready_out}, 64'd1);

    // Flush during DONE suppresses the pulse
    issue(0, 2'b00, 1'b0, 64'h77, 64'd0, 5'd13);
    @(negedge clk_in);
    check("done_valid_before_flush", {63'd0, valid_out}, 64'd1);
    flush_in = 1'b1; #1;
    check("flush_done_no_valid", {63'd0, valid_out}, 64'd0);
    @(negedge clk_in); flush_in = 1'b0;

    // Reset mid-REQ drops the request at once
    issue(1, 2'b11, 1'b0, 64'h3010, 64'd0, 5'd14);
    @(negedge clk_in);
    check("pre_reset_bus_valid", {63'd0, bus_valid_out}, 64'd1);
    rst_n_in = 1'b0; #1;
    check("reset_bus_valid", {63'd0, bus_valid_out}, 64'd0);
    check("reset_ready", {63'd0, ready_out}, 64'd1);
    @(negedge clk_in); rst_n_in = 1'b1;

    // Randomized ops against the memory model
    for (int t = 0; t < 60; t++) begin
      int k;
      k = int'($urandom_range(0, 2));
      run_op(k, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             (k == 0) ? {$urandom, $urandom} : 64'h4000 + 64'($urandom_range(0, 47)),
             {$urandom, $urandom}, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
